apb_ic_master_sched: RTL

- Shares one APB master port between NUM_MASTERS requesting cores (vmicro16 cluster).
- Round-robin arbitration; the grant is held for the whole APB transfer (SETUP to ACCESS to PREADY).
- Sequences the shared bus phases and routes PRDATA/PREADY/PSLVERR back to the granted master.
- A watchdog terminates hung transfers with an error response.

---
 rtl/apb_ic_master_sched_pkg.sv | 19 +
 rtl/apb_rr_pick.sv | 39 +++
 rtl/apb_ic_master_sched.sv | 129 ++++++++++++
 3 files changed

// File: rtl/apb_ic_master_sched_pkg.sv
// Shared definitions for the APB master scheduler: FSM encoding, default bus
// widths and the watchdog timer width helper.
package apb_ic_master_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;

  // Wide enough to hold the value TIMEOUT; never narrower than one bit.
  function automatic int timer_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin selector: first eligible requester scanning
// upward (with wrap) from the position after the last grant.
module apb_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic [N-1:0] last,
  output logic [N-1:0] pick,
  output logic         any_valid
);

  logic [N-1:0] eligible;

  assign eligible  = req & ~mask;
  assign any_valid = |eligible;

  always_comb begin
    int   last_idx;
    int   idx;
    logic found;
    last_idx = 0;
    for (int j = 0; j < N; j++) begin
      if (last[j]) last_idx = j;
    end
    pick  = '0;
    found = 1'b0;
    // Offset N lands back on the last grant, so it loses every tie.
    for (int k = 1; k <= N; k++) begin
      idx = last_idx + k;
      if (idx >= N) idx = idx - N;
      if (!found && eligible[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_ic_master_sched.sv
// Shares one APB master port among NUM_MASTERS cores: round-robin grant held
// for the whole transfer, combinational response routing, and a hang watchdog.
module apb_ic_master_sched
  import apb_ic_master_sched_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int TIMEOUT     = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            s_psel,
  input  logic [NUM_MASTERS-1:0]            s_pwrite,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_paddr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] s_pwdata,
  output logic [DATA_WIDTH-1:0]             s_prdata,
  output logic [NUM_MASTERS-1:0]            s_pready,
  output logic                              s_pslverr,
  output logic [NUM_MASTERS-1:0]            grants,
  output logic                              m_psel,
  output logic                              m_penable,
  output logic                              m_pwrite,
  output logic [ADDR_WIDTH-1:0]             m_paddr,
  output logic [DATA_WIDTH-1:0]             m_pwdata,
  input  logic [DATA_WIDTH-1:0]             m_prdata,
  input  logic                              m_pready,
  input  logic                              m_pslverr
);

  localparam int TMR_W = timer_width(TIMEOUT);

  state_t                 state_reg, state_next;
  logic [NUM_MASTERS-1:0] grants_reg, grants_next;
  logic [TMR_W-1:0]       timer_reg, timer_next;

  logic [NUM_MASTERS-1:0] pick;
  logic [NUM_MASTERS-1:0] arb_mask;
  logic                   any_valid;
  logic                   in_access;
  logic                   timed_out;
  logic                   done;

  assign in_access = (state_reg == ACCESS);
  assign timed_out = (TIMEOUT != 0) && in_access && !m_pready &&
                     (timer_reg == TMR_W'(TIMEOUT));
  assign done      = in_access && (m_pready || timed_out);
  // The finishing master still holds s_psel for the transfer that just ended.
  assign arb_mask  = done ? grants_reg : '0;

  apb_rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req       (s_psel),
    .mask      (arb_mask),
    .last      (grants_reg),
    .pick      (pick),
    .any_valid (any_valid)
  );

  always_comb begin
    state_next  = state_reg;
    grants_next = grants_reg;
    timer_next  = timer_reg;
    case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (any_valid) begin
          grants_next = pick;
          state_next  = SETUP;
        end
      end
      SETUP: begin
        timer_next = '0;
        state_next = ACCESS;
      end
      ACCESS: begin
        if (done) begin
          timer_next = '0;
          if (any_valid) begin
            grants_next = pick;
            state_next  = SETUP;
          end else begin
            state_next = IDLE;
          end
        end else if (TIMEOUT != 0) begin
          timer_next = timer_reg + TMR_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      grants_reg <= NUM_MASTERS'(1);
      timer_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      grants_reg <= grants_next;
      timer_reg  <= timer_next;
    end
  end

  assign grants    = grants_reg;
  assign m_psel    = (state_reg != IDLE);
  assign m_penable = in_access;
  assign s_pready  = done ? grants_reg : '0;
  assign s_prdata  = (in_access && m_pready) ? m_prdata : '0;
  assign s_pslverr = in_access && (m_pready ? m_pslverr : timed_out);
  assign m_pwrite  = |(grants_reg & s_pwrite);

  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] addr_terms;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] data_terms;

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_mux
    assign addr_terms[gi] = grants_reg[gi] ? s_paddr[gi*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign data_terms[gi] = grants_reg[gi] ? s_pwdata[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  always_comb begin
    m_paddr  = '0;
    m_pwdata = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_paddr  = m_paddr | addr_terms[i];
      m_pwdata = m_pwdata | data_terms[i];
    end
  end

endmodule
